// File: rtl/rd_arb_ctrl_pkg.sv
// rd_arb_ctrl_pkg: FSM encoding, default sizes and width helpers shared by the read arbiter.
package rd_arb_ctrl_pkg;
    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;
    function automatic int cw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_BURST_MAX = 4;
    localparam int DEF_STALL_MAX = 8;
    localparam int DEF_ID_W      = cw(DEF_NUM_REQ);
    localparam int DEF_BCNT_W    = cw(DEF_BURST_MAX + 1);
    localparam int DEF_SCNT_W    = cw(DEF_STALL_MAX + 1);
endpackage

// File: rtl/rd_arb_ctrl_rr_pick.sv
// rr_pick: combinational round-robin pick of the first requester after the last winner.
module rr_pick
    import rd_arb_ctrl_pkg::*;
#(
    parameter int N  = DEF_NUM_REQ,
    parameter int IW = cw(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  win,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [IW-1:0] j;
    // Scan from farthest to nearest so the nearest requester is assigned last and wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int k = N; k >= 1; k--) begin
            j = IW'((int'(last) + k) % N);
            if (req[j]) begin
                idx = j;
                any = 1'b1;
            end
        end
        win = any ? (N'(1) << idx) : '0;
    end
endmodule

// File: rtl/rd_arb_ctrl.sv
// rd_arb_ctrl: round-robin burst arbiter sharing one FIFO read port among NUM_REQ consumers.
module rd_arb_ctrl
    import rd_arb_ctrl_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_MAX = DEF_BURST_MAX,
    parameter int STALL_MAX = DEF_STALL_MAX,
    localparam int ID_W     = cw(NUM_REQ),
    localparam int BCNT_W   = cw(BURST_MAX + 1),
    localparam int SCNT_W   = cw(STALL_MAX + 1)
) (
    input  logic               rd_clk,
    input  logic               rd_rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] cons_rdy,
    input  logic               empty,
    input  logic [DATA_W-1:0]  rd_data,
    output logic               rd_en,
    output logic [NUM_REQ-1:0] gnt,
    output logic               out_valid,
    output logic [ID_W-1:0]    out_id,
    output logic [DATA_W-1:0]  out_data
);
    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_d, win;
    logic [ID_W-1:0]    g_q, g_d, last_q, last_d, win_idx;
    logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
    logic [SCNT_W-1:0]  scnt_q, scnt_d;
    logic               any, stall;

    rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
        .req  (req),
        .last (last_q),
        .win  (win),
        .idx  (win_idx),
        .any  (any)
    );

    assign rd_en = (state_q == BURST) & ~empty & req[g_q] & cons_rdy[g_q];
    assign stall = (state_q == BURST) & empty & req[g_q];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt;
        g_d     = g_q;
        last_d  = last_q;
        bcnt_d  = bcnt_q;
        scnt_d  = scnt_q;
        if (state_q == IDLE) begin
            if (any && !empty) begin
                state_d = BURST;
                gnt_d   = win;
                g_d     = win_idx;
                last_d  = win_idx;
                bcnt_d  = BCNT_W'(BURST_MAX);
                scnt_d  = '0;
            end
        end else begin
            bcnt_d = rd_en ? bcnt_q - BCNT_W'(1) : bcnt_q;
            scnt_d = rd_en ? '0 : stall ? scnt_q + SCNT_W'(1) : scnt_q;
            // Release on last pop, request drop, or the stall that reaches STALL_MAX.
            if ((rd_en && bcnt_q == BCNT_W'(1)) || !req[g_q] ||
                (stall && scnt_q == SCNT_W'(STALL_MAX - 1))) begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q   <= IDLE;
            gnt       <= '0;
            g_q       <= '0;
            last_q    <= ID_W'(NUM_REQ - 1);
            bcnt_q    <= '0;
            scnt_q    <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            out_data  <= '0;
        end else begin
            state_q   <= state_d;
            gnt       <= gnt_d;
            g_q       <= g_d;
            last_q    <= last_d;
            bcnt_q    <= bcnt_d;
            scnt_q    <= scnt_d;
            out_valid <= rd_en;
            if (rd_en) begin
                out_id   <= g_q;
                out_data <= rd_data;
            end
        end
    end
endmodule

// File: tb/tb_rd_arb_ctrl.sv
// tb_rd_arb_ctrl: scoreboard bench; a cycle model of the arbitration rules predicts pops and grants.
module tb_rd_arb_ctrl;
    localparam int NR = 4;
    localparam int BM = 4;
    localparam int SM = 8;

    logic       rd_clk, rd_rst_n, empty, rd_en, out_valid;
    logic [3:0] req, cons_rdy, gnt;
    logic [7:0] rd_data, out_data;
    logic [1:0] out_id;

    int         passed = 0, total = 0;
    logic [7:0] fifo[$];
    int         eid[$];
    logic [7:0] edat[$];
    int         ids[$];
    int         owner = -1, last = NR - 1, left = 0, stalls = 0;

    rd_arb_ctrl #(.NUM_REQ(NR), .DATA_W(8), .BURST_MAX(BM), .STALL_MAX(SM)) dut (
        .rd_clk    (rd_clk),
        .rd_rst_n  (rd_rst_n),
        .req       (req),
        .cons_rdy  (cons_rdy),
        .empty     (empty),
        .rd_data   (rd_data),
        .rd_en     (rd_en),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_id    (out_id),
        .out_data  (out_data)
    );

    initial begin
        rd_clk = 1'b0;
        forever #5 rd_clk = ~rd_clk;
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", n, a, e, $time);
    endtask

    // Drive one cycle of stimulus, compare grant/pop against the model, then advance the model.
    task automatic step(input logic [3:0] r, input logic [3:0] c, input bit push = 0, input logic [7:0] d = 8'h00);
        bit pop;
        bit found;
        @(negedge rd_clk);
        req = r;
        cons_rdy = c;
        if (push) fifo.push_back(d);
        empty = (fifo.size() == 0);
        rd_data = empty ? 8'h00 : fifo[0];
        #1;
        chk("gnt", gnt, owner < 0 ? 32'd0 : (32'd1 << owner));
        pop = owner >= 0 && r[owner] && c[owner] && !empty;
        chk("rd_en", rd_en, pop);
        if (owner < 0) begin
            if (r != 0 && !empty) begin
                found = 0;
                for (int k = 1; k <= NR; k++)
                    if (!found && r[(last + k) % NR]) begin
                        owner = (last + k) % NR;
                        found = 1;
                    end
                last = owner;
                left = BM;
                stalls = 0;
            end
        end else begin
            if (pop) begin
                eid.push_back(owner);
                edat.push_back(fifo.pop_front());
                left--;
                stalls = 0;
            end else if (empty && r[owner]) stalls++;
            if ((pop && left == 0) || !r[owner] || stalls == SM) owner = -1;
        end
    endtask

    task automatic do_reset();
        rd_rst_n = 1'b0;
        #1;
        chk("rst_rd_en", rd_en, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_id", out_id, 0);
        chk("rst_data", out_data, 0);
        owner = -1;
        last = NR - 1;
        fifo.delete();
        eid.delete();
        edat.delete();
        repeat (2) @(negedge rd_clk);
        chk("rst_hold_rd_en", rd_en, 0);
        req = 0;
        empty = 1'b1;
        rd_data = 0;
        rd_rst_n = 1'b1;
        #1;
        chk("rel_gnt", gnt, 0);
        chk("rel_valid", out_valid, 0);
    endtask

    // Monitor: every registered output word must match the oldest predicted pop.
    always @(posedge rd_clk) begin
        #2;
        if (out_valid || eid.size() != 0) begin
            chk("out_valid", out_valid, eid.size() != 0);
            if (out_valid && eid.size() != 0) begin
                chk("out_id", out_id, eid.pop_front());
                chk("out_data", out_data, edat.pop_front());
                ids.push_back(out_id);
            end else if (eid.size() != 0) begin
                void'(eid.pop_front());
                void'(edat.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] rr;
        int rate;
        int cnt;
        rd_rst_n = 1'b1;
        req = 0;
        cons_rdy = 0;
        empty = 1'b1;
        rd_data = 0;
        #2;
        do_reset();

        step(4'b0001, 4'b1111, 1, 8'hA1);
        step(4'b0001, 4'b1111);
        chk("first_gnt", gnt, 4'b0001);
        step(4'b0000, 4'b1111);
        chk("first_valid", out_valid, 1);
        chk("first_data", out_data, 8'hA1);
        chk("first_id", out_id, 0);

        do_reset();
        for (int i = 0; i < 16; i++) fifo.push_back(8'(8'h10 + i));
        ids.delete();
        repeat (22) step(4'b1111, 4'b1111);
        chk("fair_count", ids.size(), 16);
        for (int i = 0; i < 16 && i < ids.size(); i++) chk("fair_id", ids[i], i / 4);

        fifo.delete();
        ids.delete();
        step(4'b0100, 4'b1111, 1, 8'h21);
        for (int i = 0; i < 5; i++) fifo.push_back(8'(8'h22 + i));
        step(4'b0100, 4'b1111);
        step(4'b0100, 4'b1111);
        step(4'b0000, 4'b1111);
        step(4'b0000, 4'b1111);
        chk("drop_gnt", gnt, 0);
        cnt = 0;
        foreach (ids[i]) if (ids[i] == 2) cnt++;
        chk("drop_pulses", cnt, 2);

        fifo.delete();
        step(4'b0010, 4'b1111, 1, 8'h31);
        step(4'b0010, 4'b1111);
        repeat (8) step(4'b0010, 4'b1111);
        chk("stall_hold", gnt, 4'b0010);
        step(4'b0010, 4'b1111);
        chk("stall_release", gnt, 0);
        step(4'b0010, 4'b1111, 1, 8'h32);
        step(4'b0010, 4'b1111);
        repeat (4) step(4'b0010, 4'b1111);
        step(4'b0010, 4'b1111, 1, 8'h33);
        repeat (7) step(4'b0010, 4'b1111);
        chk("stall_cleared_hold", gnt, 4'b0010);
        repeat (2) step(4'b0010, 4'b1111);

        fifo.delete();
        ids.delete();
        for (int i = 0; i < 8; i++) fifo.push_back(8'(8'h40 + i));
        step(4'b0001, 4'b1111);
        step(4'b0001, 4'b1111);
        repeat (3) step(4'b0001, 4'b1110);
        chk("bp_hold", gnt, 4'b0001);
        repeat (3) step(4'b0001, 4'b1111);
        repeat (2) step(4'b0000, 4'b1111);
        cnt = 0;
        foreach (ids[i]) if (ids[i] == 0) cnt++;
        chk("bp_pops", cnt, 4);

        fifo.delete();
        for (int i = 0; i < 4; i++) fifo.push_back(8'(8'h50 + i));
        step(4'b0010, 4'b1111);
        step(4'b0010, 4'b1111);
        step(4'b0010, 4'b1111);
        do_reset();
        step(4'b1111, 4'b1111, 1, 8'h60);
        step(4'b1111, 4'b1111);
        chk("post_rst_gnt", gnt, 4'b0001);

        rr = 0;
        rate = 50;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) rate = $urandom_range(10, 90);
            if ($urandom_range(0, 3) == 0) rr = 4'($urandom);
            step(rr, 4'($urandom | $urandom), $urandom_range(0, 99) < rate, 8'($urandom));
        end
        repeat (3) step(4'b0000, 4'b1111);
        chk("drain", eid.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rd_arb_ctrl.md
RD_ARB_CTRL -- requirements
Module: rd_arb_ctrl

Interface
REQ-001 Parameter NUM_REQ, 4, number of consumers sharing the FIFO read port (2..8).
REQ-002 Parameter DATA_W, 8, FIFO word width.
REQ-003 Parameter BURST_MAX, 4, maximum pops per grant (1..16).
REQ-004 Parameter STALL_MAX, 8, consecutive empty cycles tolerated mid-burst before grant release.
REQ-005 rd_clk  in  1  single clock; all logic is on its rising edge.
REQ-006 rd_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 req  in  NUM_REQ  per-consumer read request, level.
REQ-008 cons_rdy  in  NUM_REQ  per-consumer ability to accept a word this cycle.
REQ-009 empty  in  1  FIFO empty flag, rd_clk domain.
REQ-010 rd_data  in  DATA_W  FIFO head word, valid whenever empty is low.
REQ-011 rd_en  out  1  FIFO pop, combinational.
REQ-012 gnt  out  NUM_REQ  one-hot registered grant; all-zero when idle.
REQ-013 out_valid  out  1  registered; one pulse per popped word.
REQ-014 out_id  out  clog2(NUM_REQ)  registered index of the consumer owning out_data.
REQ-015 out_data  out  DATA_W  registered popped word.

Function
REQ-016 The FSM SHALL have exactly two states: IDLE and BURST.
REQ-017 IDLE -> BURST when any req bit is high and empty is low; gnt loads the winner, burst counter loads BURST_MAX, stall counter clears.
REQ-018 Arbitration is round-robin: the winner is the first requester at or after index (last_winner+1) mod NUM_REQ; last_winner updates only on entering BURST.
REQ-019 rd_en = (state==BURST) & ~empty & req[g] & cons_rdy[g], where g is the granted index; rd_en is never high in IDLE.
REQ-020 Each cycle with rd_en high, the next edge SHALL register out_data <= rd_data, out_id <= g, out_valid <= 1, and decrement the burst counter; otherwise out_valid <= 0 and out_data/out_id hold.
REQ-021 Latency: pop in cycle N -> out_valid high in cycle N+1; back-to-back pops produce back-to-back out_valid.
REQ-022 BURST -> IDLE (gnt cleared at the same edge) when: a pop brings the counter to 0; req[g] is low; or the stall counter reaches STALL_MAX.
REQ-023 Stall counter increments on each BURST cycle with empty high and req[g] high; it clears on any pop.
REQ-024 cons_rdy[g] low with ~empty holds the grant, does not pop, and does not advance the stall counter.
REQ-025 No IDLE cycle is skipped: after BURST exits, at least one IDLE cycle precedes the next grant.
REQ-026 Requests from non-granted consumers have no effect during BURST.
REQ-027 Counter widths are clog2(BURST_MAX+1) and clog2(STALL_MAX+1); neither wraps.

Reset
REQ-028 While rd_rst_n is low: state=IDLE, gnt=0, out_valid=0, out_data=0, out_id=0, counters=0, last_winner=NUM_REQ-1 (consumer 0 wins first).
REQ-029 Reset asserted mid-burst SHALL abort the burst with no further pop; rd_en is low throughout reset.

Structure
REQ-030 A shared package holds the FSM state encoding and the clog2-derived width constants.
REQ-031 One sub-module, rr_pick, SHALL implement the combinational round-robin selection (req, last_winner -> one-hot winner, index, any).

Verification
REQ-032 Reset: after release, all outputs 0, rd_en 0; req=4'b0001 with FIFO holding 0xA1 -> gnt=0001 next edge, out_valid with out_data=0xA1, out_id=0 one cycle after the pop.
REQ-033 Fairness: req=4'b1111 held, FIFO holding 16 words, cons_rdy all high -> grants 0,1,2,3,0... each consuming 4 words, out_id sequence 0x4,1x4,2x4,3x4.
REQ-034 Burst end by request drop: consumer 2 granted, req[2] falls after 2 pops -> gnt=0 next edge, exactly 2 out_valid pulses with out_id=2.
REQ-035 Empty stall: consumer 1 granted, FIFO empties after 1 pop, stays empty 8 cycles -> grant released at the 8th stall cycle; if a word arrives at stall cycle 5 it is popped and the counter clears.
REQ-036 Backpressure: cons_rdy[0] low 3 cycles mid-burst with FIFO non-empty -> rd_en low, no stall increment, grant held, burst finishes with 4 pops total.
REQ-037 Mid-burst reset: rd_rst_n low during second pop cycle -> rd_en drops immediately, out_valid=0, next grant after release goes to consumer 0.
